// File: rtl/io_int_controller_if.sv
// Control-unit strobes, interrupt sources and peripheral port of io_int_controller.
// The controller sits on the slave side; the control unit/environment is the master.
interface io_int_controller_if;
   logic        io_read;
   logic        io_write;
   logic        io_addr_read;
   logic [3:0]  io_addr;
   logic        io_push;
   logic        io_store_retaddr;
   logic        io_push_retaddr;
   logic        io_push_ints;
   logic        io_push_int_addr;
   logic        io_interrupt;
   logic [15:0] irq_in;
   logic [3:0]  port_addr;
   logic [15:0] port_wdata;
   logic        port_we;
   logic        port_re;
   logic [15:0] port_rdata;

   modport master (
      output io_read, io_write, io_addr_read, io_addr, io_push, io_store_retaddr,
             io_push_retaddr, io_push_ints, io_push_int_addr, irq_in, port_rdata,
      input  io_interrupt, port_addr, port_wdata, port_we, port_re
   );

   modport slave (
      input  io_read, io_write, io_addr_read, io_addr, io_push, io_store_retaddr,
             io_push_retaddr, io_push_ints, io_push_int_addr, irq_in, port_rdata,
      output io_interrupt, port_addr, port_wdata, port_we, port_re
   );
endinterface

// File: rtl/io_int_controller.sv
// IO decode, interrupt latch/vectoring and return-address store for the control unit.
// Port strobes and bus drives are combinational; register updates and read captures land at the next edge.
module io_int_controller #(
   parameter logic [15:0] VEC_BASE_RST = 16'h0100
) (
   input  logic              clk,
   input  logic              rst_n,
   io_int_controller_if.slave io,
   inout  wire  [15:0]       d_bus,
   output wire  [15:0]       a_bus
);
   localparam logic [3:0] ADDR_PEND  = 4'hD;
   localparam logic [3:0] ADDR_VBASE = 4'hE;
   localparam logic [3:0] ADDR_IEN   = 4'hF;

   logic [15:0] pend, ien, vbase, ret, rdl, irq_prev;
   logic [15:0] pend_nxt, active, rise, vector, reg_rdata, d_drv;
   logic [3:0]  idx;
   logic        found, rd_ok, wr_ok, is_reg, d_en;

   assign rd_ok  = io.io_read & io.io_addr_read;
   assign wr_ok  = io.io_write & io.io_addr_read;
   assign is_reg = (io.io_addr >= ADDR_PEND);

   assign io.port_we    = wr_ok & ~is_reg;
   assign io.port_re    = rd_ok & ~is_reg;
   assign io.port_addr  = io.io_addr;
   assign io.port_wdata = d_bus;

   assign active          = pend & ien;
   assign io.io_interrupt = |active;

   // Scan downward so the lowest set bit is the one left in idx.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         if (active[i]) begin
            idx   = 4'(i);
            found = 1'b1;
         end
      end
   end

   assign vector = vbase + {12'h000, idx};
   assign a_bus  = io.io_push_int_addr ? vector : 16'hzzzz;

   always_comb begin
      case (io.io_addr)
         ADDR_PEND:  reg_rdata = pend;
         ADDR_VBASE: reg_rdata = vbase;
         default:    reg_rdata = ien;
      endcase
   end

   always_comb begin
      d_en  = 1'b1;
      d_drv = ret;
      if (io.io_push)
         d_drv = rdl;
      else if (io.io_push_ints)
         d_drv = pend;
      else if (!io.io_push_retaddr)
         d_en = 1'b0;
   end

   assign d_bus = d_en ? d_drv : 16'hzzzz;

   // New edges are OR'd in last so they win over W1C and acknowledge clears.
   assign rise = io.irq_in & ~irq_prev;
   always_comb begin
      pend_nxt = pend;
      if (wr_ok && io.io_addr == ADDR_PEND)
         pend_nxt = pend_nxt & ~d_bus;
      if (io.io_push_int_addr && found)
         pend_nxt[idx] = 1'b0;
      pend_nxt = pend_nxt | rise;
   end

   always_ff @(posedge clk) begin
      irq_prev <= io.irq_in;
      if (!rst_n) begin
         pend  <= '0;
         ien   <= '0;
         vbase <= VEC_BASE_RST;
         ret   <= '0;
         rdl   <= '0;
      end else begin
         pend <= pend_nxt;
         if (wr_ok && io.io_addr == ADDR_VBASE)
            vbase <= d_bus;
         if (wr_ok && io.io_addr == ADDR_IEN)
            ien <= d_bus;
         if (io.io_store_retaddr)
            ret <= d_bus;
         if (rd_ok)
            rdl <= is_reg ? reg_rdata : io.port_rdata;
      end
   end
endmodule

// File: tb/tb_io_int_controller.sv
// Directed bench for io_int_controller: comb decode table, register table, interrupt and bus sequences.
module tb_io_int_controller;
   logic clk = 1'b0;
   logic rst_n;
   logic        tb_en;
   logic [15:0] tb_dat;
   tri1  [15:0] d_bus;
   tri1  [15:0] a_bus;
   int n_chk  = 0;
   int n_pass = 0;

   io_int_controller_if bus ();

   io_int_controller #(.VEC_BASE_RST(16'h0100)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus),
      .d_bus (d_bus),
      .a_bus (a_bus)
   );

   assign d_bus = tb_en ? tb_dat : 16'hzzzz;

   always #5 clk = ~clk;

   typedef struct {
      logic        wr;
      logic        rd;
      logic        qual;
      logic [3:0]  addr;
      logic [15:0] dat;
      logic        exp_we;
      logic        exp_re;
   } comb_vec_t;

   typedef struct {
      logic [3:0]  addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } reg_vec_t;

   comb_vec_t cv[10];
   reg_vec_t  rv[5];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.io_read          = 1'b0;
      bus.io_write         = 1'b0;
      bus.io_addr_read     = 1'b0;
      bus.io_push          = 1'b0;
      bus.io_store_retaddr = 1'b0;
      bus.io_push_retaddr  = 1'b0;
      bus.io_push_ints     = 1'b0;
      bus.io_push_int_addr = 1'b0;
      tb_en                = 1'b0;
   endtask

   task automatic reg_wr(input logic [3:0] a, input logic [15:0] d);
      bus.io_write     = 1'b1;
      bus.io_addr_read = 1'b1;
      bus.io_addr      = a;
      tb_dat           = d;
      tb_en            = 1'b1;
      tick();
      idle();
   endtask

   task automatic reg_rd(input logic [3:0] a, output logic [15:0] d);
      bus.io_read      = 1'b1;
      bus.io_addr_read = 1'b1;
      bus.io_addr      = a;
      tick();
      idle();
      bus.io_push = 1'b1;
      #1;
      d = d_bus;
      bus.io_push = 1'b0;
   endtask

   task automatic peek_pend(output logic [15:0] d);
      bus.io_push_ints = 1'b1;
      #1;
      d = d_bus;
      bus.io_push_ints = 1'b0;
   endtask

   task automatic pulse_irq(input logic [15:0] m);
      bus.irq_in = m;
      tick();
      bus.irq_in = 16'h0000;
      tick();
   endtask

   task automatic ack(input string name, input logic [15:0] exp_vec);
      bus.io_push_int_addr = 1'b1;
      #1;
      check(name, a_bus, exp_vec);
      tick();
      bus.io_push_int_addr = 1'b0;
   endtask

   initial begin
      logic [15:0] v;

      cv[0] = '{1'b1, 1'b0, 1'b1, 4'h3, 16'hBEEF, 1'b1, 1'b0};
      cv[1] = '{1'b1, 1'b0, 1'b0, 4'h3, 16'hBEEF, 1'b0, 1'b0};
      cv[2] = '{1'b1, 1'b0, 1'b1, 4'hC, 16'h5555, 1'b1, 1'b0};
      cv[3] = '{1'b1, 1'b0, 1'b1, 4'hD, 16'h0000, 1'b0, 1'b0};
      cv[4] = '{1'b0, 1'b1, 1'b1, 4'h0, 16'h0000, 1'b0, 1'b1};
      cv[5] = '{1'b0, 1'b1, 1'b0, 4'h0, 16'h0000, 1'b0, 1'b0};
      cv[6] = '{1'b0, 1'b1, 1'b1, 4'hC, 16'h0000, 1'b0, 1'b1};
      cv[7] = '{1'b0, 1'b1, 1'b1, 4'hE, 16'h0000, 1'b0, 1'b0};
      cv[8] = '{1'b0, 1'b1, 1'b1, 4'hF, 16'h0000, 1'b0, 1'b0};
      cv[9] = '{1'b1, 1'b0, 1'b1, 4'h0, 16'hA5A5, 1'b1, 1'b0};

      rv[0] = '{4'hF, 16'h00A0, 16'h00A0};
      rv[1] = '{4'hE, 16'h1234, 16'h1234};
      rv[2] = '{4'hF, 16'hFFFF, 16'hFFFF};
      rv[3] = '{4'hE, 16'h0100, 16'h0100};
      rv[4] = '{4'hF, 16'h0000, 16'h0000};

      idle();
      bus.io_addr    = 4'h0;
      bus.port_rdata = 16'h0000;
      tb_dat         = 16'h0000;
      bus.irq_in     = 16'h0001;
      rst_n          = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Reset state, with irq_in[0] held high across reset.
      check("rst_interrupt", {15'h0, bus.io_interrupt}, 16'h0000);
      peek_pend(v);
      check("rst_pend", v, 16'h0000);
      bus.io_push = 1'b1;
      #1;
      check("rst_rdl", d_bus, 16'h0000);
      bus.io_push = 1'b0;
      reg_rd(4'hE, v);
      check("rst_vbase", v, 16'h0100);
      reg_wr(4'hF, 16'h0001);
      check("held_src_no_edge", {15'h0, bus.io_interrupt}, 16'h0000);
      bus.irq_in = 16'h0000;
      reg_wr(4'hF, 16'h0000);

      // Combinational decode table.
      for (int i = 0; i < 10; i++) begin
         bus.io_write     = cv[i].wr;
         bus.io_read      = cv[i].rd;
         bus.io_addr_read = cv[i].qual;
         bus.io_addr      = cv[i].addr;
         tb_dat           = cv[i].dat;
         tb_en            = cv[i].wr;
         #1;
         check($sformatf("cv%0d_we", i), {15'h0, bus.port_we}, {15'h0, cv[i].exp_we});
         check($sformatf("cv%0d_re", i), {15'h0, bus.port_re}, {15'h0, cv[i].exp_re});
         if (cv[i].exp_we) begin
            check($sformatf("cv%0d_wdata", i), bus.port_wdata, cv[i].dat);
            check($sformatf("cv%0d_paddr", i), {12'h0, bus.port_addr}, {12'h0, cv[i].addr});
         end
         idle();
         #1;
      end
      check("we_drops_after", {15'h0, bus.port_we}, 16'h0000);

      // Peripheral read through RDL, and RDL holding.
      bus.port_rdata = 16'h1234;
      reg_rd(4'h3, v);
      check("port_read", v, 16'h1234);
      bus.port_rdata = 16'h9999;
      tick();
      bus.io_push = 1'b1;
      #1;
      check("rdl_hold", d_bus, 16'h1234);
      bus.io_push = 1'b0;

      // Internal register write/read table.
      for (int i = 0; i < 5; i++) begin
         reg_wr(rv[i].addr, rv[i].wdata);
         reg_rd(rv[i].addr, v);
         check($sformatf("rv%0d", i), v, rv[i].exp);
      end

      // Two enabled sources, acknowledged lowest first.
      reg_wr(4'hF, 16'h00A0);
      bus.irq_in = 16'h0080;
      tick();
      check("irq_latency", {15'h0, bus.io_interrupt}, 16'h0001);
      bus.irq_in = 16'h0000;
      tick();
      pulse_irq(16'h0020);
      check("irq_two_pending", {15'h0, bus.io_interrupt}, 16'h0001);
      peek_pend(v);
      check("pend_a0", v, 16'h00A0);
      ack("vec_105", 16'h0105);
      peek_pend(v);
      check("pend_80", v, 16'h0080);
      check("irq_still", {15'h0, bus.io_interrupt}, 16'h0001);
      ack("vec_107", 16'h0107);
      check("irq_cleared", {15'h0, bus.io_interrupt}, 16'h0000);
      ack("vec_none", 16'h0100);

      // Edge beats W1C in the same cycle, then a plain W1C clear.
      bus.irq_in = 16'h0004;
      reg_wr(4'hD, 16'h0004);
      bus.irq_in = 16'h0000;
      peek_pend(v);
      check("edge_beats_w1c", v, 16'h0004);
      reg_wr(4'hD, 16'h0004);
      peek_pend(v);
      check("w1c_clear", v, 16'h0000);

      // Edge beats acknowledge in the same cycle.
      pulse_irq(16'h0004);
      reg_wr(4'hF, 16'h0004);
      bus.irq_in = 16'h0004;
      ack("vec_102", 16'h0102);
      bus.irq_in = 16'h0000;
      peek_pend(v);
      check("edge_beats_ack", v, 16'h0004);

      // Vector wraps modulo 2^16.
      reg_wr(4'hE, 16'hFFFF);
      ack("vec_wrap", 16'h0001);
      check("irq_after_wrap", {15'h0, bus.io_interrupt}, 16'h0000);

      // Unqualified write changes nothing.
      bus.io_write = 1'b1;
      bus.io_addr  = 4'hF;
      tb_dat       = 16'h1234;
      tb_en        = 1'b1;
      #1;
      check("unqual_we", {15'h0, bus.port_we}, 16'h0000);
      tick();
      idle();
      reg_rd(4'hF, v);
      check("unqual_ien", v, 16'h0004);

      // Return address store/push and bus priority.
      tb_dat               = 16'h0042;
      tb_en                = 1'b1;
      bus.io_store_retaddr = 1'b1;
      tick();
      idle();
      #1;
      check("d_bus_idle_z", d_bus, 16'hFFFF);
      check("a_bus_idle_z", a_bus, 16'hFFFF);
      bus.io_push_retaddr = 1'b1;
      #1;
      check("ret_push", d_bus, 16'h0042);
      bus.io_push = 1'b1;
      #1;
      check("prio_push", d_bus, 16'h0004);
      bus.io_push      = 1'b0;
      bus.io_push_ints = 1'b1;
      #1;
      check("prio_ints", d_bus, 16'h0000);
      idle();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
